// File: rtl/onehot_gen_32.sv
// One-hot word generator: a start request walks a single set bit from position 0 up to
// the requested amount, one position per cycle, then pulses done for one cycle.
module onehot_gen_32 (
    input  logic        clk,
    input  logic        rst,
    input  logic        start,
    input  logic [5:0]  amt,
    output logic        busy,
    output logic        done,
    output logic [31:0] out,
    output logic        ovf
);

    typedef enum logic [1:0] {
        StIdle  = 2'b00,
        StShift = 2'b01,
        StDone  = 2'b10
    } state_e;

    state_e      state_q, state_d;
    logic [31:0] out_q, out_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        ovf_q, ovf_d;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        ovf_d   = ovf_q;
        case (state_q)
            StIdle: begin
                if (start) begin
                    // Amounts past the word width skip shifting and report overflow at once.
                    if (amt[5]) begin
                        state_d = StDone;
                        out_d   = '0;
                        ovf_d   = 1'b1;
                    end else begin
                        state_d = StShift;
                        out_d   = 32'h0000_0001;
                        cnt_d   = amt[4:0];
                        ovf_d   = 1'b0;
                    end
                end
            end
            StShift: begin
                if (cnt_q != 5'd0) begin
                    out_d = out_q << 1;
                    cnt_d = cnt_q - 5'd1;
                end else begin
                    state_d = StDone;
                end
            end
            StDone: begin
                state_d = StIdle;
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
            out_q   <= '0;
            cnt_q   <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            ovf_q   <= ovf_d;
        end
    end

    // Status is decoded from the state register only, so start/amt never reach it directly.
    assign done = (state_q == StDone);
    assign busy = (state_q == StShift) || (state_q == StDone);
    assign out  = out_q;
    assign ovf  = ovf_q;

endmodule
